// File: rtl/spwm_gate_driver.sv
// Three-phase sinusoidal PWM gate driver.
// Triangular carrier, shadowed references, per-leg dead-time FSM.
module spwm_gate_driver #(
  parameter int DATA_W       = 12,
  parameter int CARRIER_PEAK = 4095,
  parameter int PRESCALE     = 1,
  parameter int DEADTIME     = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] ref_a,
  input  logic [DATA_W-1:0] ref_b,
  input  logic [DATA_W-1:0] ref_c,
  output logic [2:0]        gate_h,
  output logic [2:0]        gate_l,
  output logic [DATA_W-1:0] carrier,
  output logic              carrier_valley
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(DEADTIME + 1);

  localparam logic [DATA_W-1:0] PEAK = DATA_W'(CARRIER_PEAK);
  localparam logic [DATA_W-1:0] ZERO = '0;
  localparam logic [DATA_W-1:0] ONE  = DATA_W'(1);
  localparam logic [DATA_W-1:0] MID  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [PW-1:0]     PLAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0]     DT_LOAD = DW'(DEADTIME - 1);

  typedef enum logic [1:0] {
    OFF = 2'd0,
    DT  = 2'd1,
    HI  = 2'd2,
    LO  = 2'd3
  } leg_t;

  logic [PW-1:0]     psc;
  logic              tick;
  logic [DATA_W-1:0] cnt;
  logic              dir_up;
  logic [DATA_W-1:0] refs [3];
  logic [DATA_W-1:0] u [3];
  logic [2:0]        cmd;
  leg_t              state [3];
  logic [DW-1:0]     dt [3];

  assign tick    = (psc == PLAST);
  assign carrier = cnt;
  assign refs[0] = ref_a;
  assign refs[1] = ref_b;
  assign refs[2] = ref_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psc            <= '0;
      cnt            <= '0;
      dir_up         <= 1'b1;
      carrier_valley <= 1'b0;
    end else begin
      psc            <= tick ? '0 : psc + 1'b1;
      carrier_valley <= tick && (cnt == ZERO);
      if (tick) begin
        if (dir_up && cnt == PEAK) begin
          dir_up <= 1'b0;
          cnt    <= PEAK - ONE;
        end else if (!dir_up && cnt == ZERO) begin
          dir_up <= 1'b1;
          cnt    <= ONE;
        end else if (dir_up) begin
          cnt <= cnt + ONE;
        end else begin
          cnt <= cnt - ONE;
        end
      end
    end
  end

  // Refs are only latched at the carrier turning points.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) u[i] <= MID;
      cmd <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        cmd[i] <= (u[i] > cnt);
        if (tick && (cnt == ZERO || cnt == PEAK))
          u[i] <= refs[i] ^ MID;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        state[i] <= OFF;
        dt[i]    <= '0;
      end
      gate_h <= '0;
      gate_l <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        gate_h[i] <= 1'b0;
        gate_l[i] <= 1'b0;
        if (!enable) begin
          state[i] <= OFF;
        end else begin
          unique case (state[i])
            OFF: begin
              state[i] <= DT;
              dt[i]    <= DT_LOAD;
            end
            DT: begin
              if (dt[i] == '0) begin
                state[i]  <= cmd[i] ? HI : LO;
                gate_h[i] <= cmd[i];
                gate_l[i] <= !cmd[i];
              end else begin
                dt[i] <= dt[i] - 1'b1;
              end
            end
            HI: begin
              if (!cmd[i]) begin
                state[i] <= DT;
                dt[i]    <= DT_LOAD;
              end else begin
                gate_h[i] <= 1'b1;
              end
            end
            LO: begin
              if (cmd[i]) begin
                state[i] <= DT;
                dt[i]    <= DT_LOAD;
              end else begin
                gate_l[i] <= 1'b1;
              end
            end
            default: state[i] <= OFF;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_spwm_gate_driver.sv
// Randomized bench for spwm_gate_driver.
// Timestamp-based reference model of carrier, shadow refs and dead time.
module tb_spwm_gate_driver;

  localparam int W    = 12;
  localparam int PEAK = 4095;
  localparam int DTM  = 24;
  localparam int PER  = 2 * PEAK;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [W-1:0] ref_a, ref_b, ref_c;
  logic [2:0]   gate_h, gate_l;
  logic [W-1:0] carrier;
  logic         carrier_valley;

  spwm_gate_driver #(
    .DATA_W(W), .CARRIER_PEAK(PEAK),
    .PRESCALE(1), .DEADTIME(DTM)
  ) u_dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ref_a(ref_a), .ref_b(ref_b), .ref_c(ref_c),
    .gate_h(gate_h), .gate_l(gate_l),
    .carrier(carrier), .carrier_valley(carrier_valley)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)",
               tag, obs, exp, $time);
    end
  endtask

  // Model: leg mode 0=off 1=deadtime 2=high 3=low
  int n;
  int mu [3];
  bit mcmd [3];
  int mode [3];
  int rel [3];
  bit mval;

  function automatic int tri_f(input int k);
    int p;
    p = k % PER;
    return (p <= PEAK) ? p : PER - p;
  endfunction

  task automatic model_reset();
    n = 0;
    mval = 0;
    for (int i = 0; i < 3; i++) begin
      mu[i] = 2048; mcmd[i] = 0; mode[i] = 0; rel[i] = 0;
    end
  endtask

  // Advance the model across the coming rising edge.
  task automatic model_step();
    int c, e;
    int r [3];
    bit old;
    c = tri_f(n);
    e = n + 1;
    r[0] = ref_a; r[1] = ref_b; r[2] = ref_c;
    for (int i = 0; i < 3; i++) begin
      old = mcmd[i];
      if (!enable) mode[i] = 0;
      else if (mode[i] == 0) begin
        mode[i] = 1; rel[i] = e + DTM;
      end else if (mode[i] == 1) begin
        if (e == rel[i]) mode[i] = old ? 2 : 3;
      end else if ((mode[i] == 2) != old) begin
        mode[i] = 1; rel[i] = e + DTM;
      end
      mcmd[i] = (mu[i] > c);
      if (c == 0 || c == PEAK) mu[i] = r[i] ^ 2048;
    end
    mval = (c == 0);
    n++;
  endtask

  task automatic check_all();
    logic [2:0] eh, el;
    for (int i = 0; i < 3; i++) begin
      eh[i] = (mode[i] == 2);
      el[i] = (mode[i] == 3);
    end
    chk("carrier", carrier, tri_f(n));
    chk("valley", carrier_valley, mval);
    chk("gate_h", gate_h, eh);
    chk("gate_l", gate_l, el);
    chk("interlock", gate_h & gate_l, 0);
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [W-1:0] pick_ref();
    unique case ($urandom_range(0, 4))
      0: return 12'h7FF;
      1: return 12'h800;
      2: return 12'h000;
      default: return W'($urandom);
    endcase
  endfunction

  int ch, cl, bh, bl;

  initial begin
    rst = 1'b1; enable = 1'b1;
    ref_a = '0; ref_b = '0; ref_c = '0;
    repeat (3) @(negedge clk);
    chk("rst_gate_h", gate_h, 0);
    chk("rst_gate_l", gate_l, 0);
    rst = 1'b0;
    model_reset();
    check_all();

    // All refs zero: 50% duty per leg
    ch = 0; cl = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      cycle();
      if (i >= PER) begin
        ch += int'(gate_h[0]);
        cl += int'(gate_l[0]);
      end
    end
    chk("zero_ref_h_clks", ch, PER / 2 - DTM);
    chk("zero_ref_l_clks", cl, PER / 2 - DTM);

    // Full-scale refs
    ref_a = 12'h7FF; ref_b = 12'h800; ref_c = 12'h000;
    ch = 0; cl = 0; bh = 0; bl = 0;
    for (int i = 0; i < 2 * PER; i++) begin
      cycle();
      if (i >= PER) begin
        ch += int'(gate_h[0]);
        cl += int'(gate_l[0]);
        bh += int'(gate_h[1]);
        bl += int'(gate_l[1]);
      end
    end
    chk("max_ref_h_clks", ch, PER - DTM);
    chk("max_ref_l_clks", cl, 0);
    chk("min_ref_h_clks", bh, 0);
    chk("min_ref_l_clks", bl, PER);

    // Random refs and enable toggling
    for (int i = 0; i < 20000; i++) begin
      if ($urandom_range(0, 499) == 0) ref_a = pick_ref();
      if ($urandom_range(0, 499) == 0) ref_b = pick_ref();
      if ($urandom_range(0, 499) == 0) ref_c = pick_ref();
      if ($urandom_range(0, 1999) == 0) enable = ~enable;
      cycle();
    end

    // Asynchronous reset while switching
    enable = 1'b1;
    ref_a = 12'h000; ref_b = 12'h7FF; ref_c = 12'h400;
    for (int i = 0; i < 3000; i++) cycle();
    chk("pre_rst_active", |(gate_h | gate_l), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_gate_h", gate_h, 0);
    chk("async_gate_l", gate_l, 0);
    chk("async_carrier", carrier, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_all();
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 299) == 0) ref_c = pick_ref();
      if ($urandom_range(0, 999) == 0) enable = ~enable;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
